// File: rtl/half_adder_or_gate_pkg.sv
// rtl/half_adder_or_gate_pkg.sv - shared constants for the half-adder/OR ripple adder
package half_adder_or_gate_pkg;

  localparam int unsigned HAOG_DEFAULT_WIDTH = 4;
  localparam int unsigned HAOG_MAX_WIDTH     = 32;

  typedef struct packed {
    logic s;
    logic c;
  } ha_out_t;

  function automatic bit haog_width_legal(input int unsigned w);
    return (w >= 1) && (w <= HAOG_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single-bit half adder (sum = x^y, carry = x&y)
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/half_adder_or_gate.sv
// rtl/half_adder_or_gate.sv - registered ripple adder built from half-adder pairs plus OR
// Optional signed-overflow output enabled by HALF_ADDER_OR_GATE_OVF_EN.
module half_adder_or_gate
  import half_adder_or_gate_pkg::*;
#(
  parameter int unsigned WIDTH = HAOG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef HALF_ADDER_OR_GATE_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (!haog_width_legal(WIDTH)) begin : g_width_check
    $error("half_adder_or_gate: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen1;
  logic [WIDTH-1:0] gen2;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  assign carry[0] = cin;

  // Two half adders per bit; the OR merges their carries into the ripple chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder_cell u_ha1 (
      .x (a[i]),
      .y (b[i]),
      .s (prop[i]),
      .c (gen1[i])
    );

    half_adder_cell u_ha2 (
      .x (prop[i]),
      .y (carry[i]),
      .s (sum_d[i]),
      .c (gen2[i])
    );

    assign carry[i+1] = gen1[i] | gen2[i];
  end

  assign cout_d = carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef HALF_ADDER_OR_GATE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_half_adder_or_gate.sv
// tb/tb_half_adder_or_gate.sv - scoreboard bench for half_adder_or_gate at WIDTH 8, 4 and 1
module tb_half_adder_or_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, in_valid;

  logic [7:0] sum8;
  logic [3:0] sum4;
  logic       sum1;
  logic       cout8, cout4, cout1;
  logic       ov8, ov4, ov1;
  logic       ovf8, ovf4, ovf1;

  always #5 clk = ~clk;

  half_adder_or_gate #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum8), .cout(cout8), .out_valid(ov8)
`ifdef HALF_ADDER_OR_GATE_OVF_EN
    , .ovf(ovf8)
`endif
  );

  half_adder_or_gate #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a[3:0]), .b(b[3:0]), .cin(cin), .in_valid(in_valid),
    .sum(sum4), .cout(cout4), .out_valid(ov4)
`ifdef HALF_ADDER_OR_GATE_OVF_EN
    , .ovf(ovf4)
`endif
  );

  half_adder_or_gate #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .cin(cin), .in_valid(in_valid),
    .sum(sum1), .cout(cout1), .out_valid(ov1)
`ifdef HALF_ADDER_OR_GATE_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef HALF_ADDER_OR_GATE_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  typedef struct {
    int s8; int c8; int o8;
    int s4; int c4; int o4;
    int s1; int c1; int o1;
  } exp_t;

  exp_t q[$];
  exp_t last = '{default: 0};
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Arithmetic reference: unsigned sum/carry and signed-range overflow.
  function automatic void ref_add(input int w, input int av, input int bv, input int ci,
                                  output int s, output int c, output int o);
    int m, x, y, full, sx, sy, r;
    m    = 1 << w;
    x    = av % m;
    y    = bv % m;
    full = x + y + ci;
    s    = full % m;
    c    = full / m;
    sx   = (x >= m / 2) ? x - m : x;
    sy   = (y >= m / 2) ? y - m : y;
    r    = sx + sy + ci;
    o    = ((r > m / 2 - 1) || (r < -(m / 2))) ? 1 : 0;
  endfunction

  function automatic exp_t make_exp(input int av, input int bv, input int ci);
    exp_t e;
    ref_add(8, av, bv, ci, e.s8, e.c8, e.o8);
    ref_add(4, av, bv, ci, e.s4, e.c4, e.o4);
    ref_add(1, av, bv, ci, e.s1, e.c1, e.o1);
    return e;
  endfunction

  task automatic cycle(input bit v, input int av, input int bv, input int ci);
    in_valid = v;
    a        = av[7:0];
    b        = bv[7:0];
    cin      = ci[0];
    @(posedge clk);
    if (v) q.push_back(make_exp(av, bv, ci));
    #2;
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    check({tag, "_sum8"},  sum8,  e.s8[7:0]);
    check({tag, "_cout8"}, cout8, e.c8[0]);
    check({tag, "_sum4"},  sum4,  e.s4[3:0]);
    check({tag, "_cout4"}, cout4, e.c4[0]);
    check({tag, "_sum1"},  sum1,  e.s1[0]);
    check({tag, "_cout1"}, cout1, e.c1[0]);
`ifdef HALF_ADDER_OR_GATE_OVF_EN
    check({tag, "_ovf8"}, ovf8, e.o8[0]);
    check({tag, "_ovf4"}, ovf4, e.o4[0]);
    check({tag, "_ovf1"}, ovf1, e.o1[0]);
`endif
  endtask

  // Monitor: pops one expected result whenever any instance flags a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ov8 === 1'b1 || ov4 === 1'b1 || ov1 === 1'b1) begin
        check("result_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          last = e;
          check("out_valid8", ov8, 1'b1);
          check("out_valid4", ov4, 1'b1);
          check("out_valid1", ov1, 1'b1);
          cmp_all("result", e);
        end
      end else begin
        check("idle_out_valid4", ov4, 1'b0);
        check("idle_out_valid1", ov1, 1'b0);
        cmp_all("hold", last);
      end
    end
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #12;
    check("reset_sum8", sum8, 8'h00);
    check("reset_cout8", cout8, 1'b0);
    check("reset_out_valid8", ov8, 1'b0);
    rst_n = 1'b1;

    // Single-bit truth cases, WIDTH=4 wrap cases, full wrap, overflow cases.
    cycle(1, 8'h00, 8'h00, 0);
    cycle(1, 8'h00, 8'h00, 1);
    cycle(1, 8'h00, 8'h01, 0);
    cycle(1, 8'h00, 8'h01, 1);
    cycle(1, 8'h0F, 8'h01, 0);
    cycle(1, 8'h0F, 8'h0F, 1);
    cycle(1, 8'hFF, 8'hFF, 1);
    cycle(1, 8'h07, 8'h01, 0);
    cycle(1, 8'h08, 8'h08, 0);
    cycle(1, 8'h7F, 8'h01, 0);
    cycle(1, 8'h80, 8'h80, 0);

    // One valid pulse followed by three idle cycles.
    cnt = 0;
    cycle(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    if (ov8 === 1'b1) cnt++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
      if (ov8 === 1'b1) cnt++;
    end
    check("pulse_out_valid_count", cnt, 1);

    // Asynchronous reset between edges while a result is presented.
    cycle(1, 8'hC3, 8'h5A, 1);
    check("pre_reset_out_valid8", ov8, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_sum8", sum8, 8'h00);
    check("async_reset_cout8", cout8, 1'b0);
    check("async_reset_out_valid8", ov8, 1'b0);
    check("async_reset_sum4", sum4, 4'h0);
    q.delete();
    last = '{default: 0};

    // Valid input held during reset must not produce a result.
    in_valid = 1'b1;
    a        = 8'hAA;
    b        = 8'h55;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1));
    end

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/half_adder_or_gate.md
HALF_ADDER_OR_GATE -- requirements
Module: half_adder_or_gate

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 1..32).
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port a  input  WIDTH  operand A, unsigned.
REQ-005 Port b  input  WIDTH  operand B, unsigned.
REQ-006 Port cin  input  1  carry-in into bit 0.
REQ-007 Port in_valid  input  1  qualifies a, b and cin in the current cycle.
REQ-008 Port sum  output  WIDTH  registered sum bits.
REQ-009 Port cout  output  1  registered carry-out of the MSB.
REQ-010 Port out_valid  output  1  registered; high when sum and cout hold a new result.
REQ-011 Port ovf  output  1  registered signed overflow; present only when HALF_ADDER_OR_GATE_OVF_EN is defined.

Function
REQ-012 Each bit i SHALL form a full adder from two half-adder cells and one 2-input OR: HA1(a[i],b[i]) -> p,g1; HA2(p,c[i]) -> sum bit,g2; c[i+1] = g1 OR g2.
REQ-013 Half-adder cell: sum = x XOR y, carry = x AND y.
REQ-014 Carries SHALL ripple: c[0]=cin, cout=c[WIDTH]; no carry-lookahead.
REQ-015 Combinational result {cout,sum} SHALL equal a + b + cin modulo 2^(WIDTH+1).
REQ-016 Latency one cycle: inputs sampled at edge N with in_valid=1 appear on sum/cout at edge N.
REQ-017 in_valid=0 at an edge: sum, cout (and ovf) SHALL hold their previous values; out_valid SHALL go 0.
REQ-018 out_valid SHALL equal in_valid registered one cycle earlier; back-to-back valid inputs yield back-to-back results.
REQ-019 Wrap-around: all-ones + all-ones + 1 SHALL give sum all-ones, cout=1.
REQ-020 No internal state beyond the output registers; no handshake back-pressure.

Reset
REQ-021 rst_n low SHALL immediately clear sum, cout, out_valid (and ovf) to 0, regardless of clk.
REQ-022 Reset asserted mid-stream discards the in-flight result; first edge with rst_n high samples normally.

Configuration
REQ-023 Macro HALF_ADDER_OR_GATE_OVF_EN defined: ovf port exists, registered with sum, ovf = c[WIDTH] XOR c[WIDTH-1].
REQ-024 Macro undefined: no ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-025 Package half_adder_or_gate_pkg SHALL hold the default WIDTH constant and the max-width constant 32.
REQ-026 One sub-module half_adder_cell (ports x, y, s, c) SHALL be instantiated 2*WIDTH times via generate; the OR is inline.

Verification
REQ-027 WIDTH=1: a=0,b=0,cin=0 -> sum=0,cout=0; a=0,b=0,cin=1 -> sum=1,cout=0; a=0,b=1,cin=0 -> sum=1,cout=0; a=0,b=1,cin=1 -> sum=0,cout=1; each one cycle after sampling.
REQ-028 WIDTH=4: a=0xF,b=0x1,cin=0 -> sum=0x0,cout=1,out_valid=1 next cycle; a=0xF,b=0xF,cin=1 -> sum=0xF,cout=1.
REQ-029 in_valid pulse then low for 3 cycles -> result held, out_valid high exactly one cycle.
REQ-030 rst_n low between edges while out_valid=1 -> sum=0,cout=0,out_valid=0 immediately, before next edge.
REQ-031 OVF_EN defined, WIDTH=4: a=0x7,b=0x1,cin=0 -> sum=0x8,ovf=1; a=0x8,b=0x8 -> sum=0x0,cout=1,ovf=1.
REQ-032 Random 10000 vectors, WIDTH=8: {cout,sum} matches a+b+cin one cycle later.
